// File: rtl/rpn_eval.sv
// rpn_eval: evaluates an RPN character stream ('0'-'9', '+', '-', '*', '=') on a WIDTH-bit signed stack.
// Define RPN_EVAL_DIV_EN to add '/' through a WIDTH-cycle restoring divider (DIV state).
module rpn_eval #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_STB,
  input  logic [7:0]       IN_CHAR,
  output logic             IN_ACK,
  output logic             RES_STB,
  output logic [WIDTH-1:0] RES_VAL,
  output logic             RES_ERR,
  output logic [2:0]       RES_CODE,
  input  logic             RES_ACK,
  output logic             BUSY
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int DW = $clog2(DEPTH + 1);
  localparam logic [2:0] CODE_UNDER   = 3'd1;
  localparam logic [2:0] CODE_OVER    = 3'd2;
  localparam logic [2:0] CODE_ILLEGAL = 3'd4;
  localparam logic [2:0] CODE_UNBAL   = 3'd5;

`ifdef RPN_EVAL_DIV_EN
  typedef enum logic [1:0] {IDLE, EXEC, DIV, DONE} state_t;
  localparam logic [2:0] CODE_DIV0 = 3'd3;
  localparam int CW = $clog2(WIDTH);
`else
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
`endif

  state_t           state_reg, state_next;
  logic [DW-1:0]    depth_reg, depth_next;
  logic             err_reg, err_next;
  logic [2:0]       code_reg, code_next;
  logic [7:0]       char_reg, char_next;
  logic             ack_reg, ack_next;
  logic             res_stb_reg, res_stb_next;
  logic [WIDTH-1:0] res_val_reg, res_val_next;

  logic [WIDTH-1:0] stack_mem [DEPTH];
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [AW-1:0]    idx_a, idx_b, idx_push;
  logic [WIDTH-1:0] top_a, top_b, arith_res;
  logic             is_digit, is_arith;

  assign idx_b    = AW'(depth_reg - DW'(1));
  assign idx_a    = AW'(depth_reg - DW'(2));
  assign idx_push = AW'(depth_reg);
  assign top_b    = stack_mem[idx_b];
  assign top_a    = stack_mem[idx_a];
  assign is_digit = (char_reg >= 8'h30) && (char_reg <= 8'h39);
  assign is_arith = (char_reg == 8'h2B) || (char_reg == 8'h2D) || (char_reg == 8'h2A);

  always_comb begin
    case (char_reg)
      8'h2B:   arith_res = top_a + top_b;
      8'h2D:   arith_res = top_a - top_b;
      default: arith_res = top_a * top_b;
    endcase
  end

`ifdef RPN_EVAL_DIV_EN
  logic [CW-1:0]    div_cnt_reg, div_cnt_next;
  logic [WIDTH-1:0] div_quo_reg, div_quo_next;
  logic [WIDTH-1:0] div_den_reg, div_den_next;
  logic [WIDTH-1:0] div_rem_reg, div_rem_next;
  logic             div_neg_reg, div_neg_next;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH-1:0] rem_step, quo_shift, quo_signed;

  // One restoring step on magnitudes; the sign is applied only to the final quotient.
  always_comb begin
    rem_shift = {div_rem_reg, div_quo_reg[WIDTH-1]};
    quo_shift = {div_quo_reg[WIDTH-2:0], 1'b0};
    rem_step  = rem_shift[WIDTH-1:0];
    if (rem_shift >= {1'b0, div_den_reg}) begin
      rem_step     = WIDTH'(rem_shift - {1'b0, div_den_reg});
      quo_shift[0] = 1'b1;
    end
    quo_signed = div_neg_reg ? -quo_shift : quo_shift;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      div_cnt_reg <= '0;
      div_quo_reg <= '0;
      div_den_reg <= '0;
      div_rem_reg <= '0;
      div_neg_reg <= 1'b0;
    end else begin
      div_cnt_reg <= div_cnt_next;
      div_quo_reg <= div_quo_next;
      div_den_reg <= div_den_next;
      div_rem_reg <= div_rem_next;
      div_neg_reg <= div_neg_next;
    end
  end
`endif

  always_comb begin
    state_next   = state_reg;
    depth_next   = depth_reg;
    err_next     = err_reg;
    code_next    = code_reg;
    char_next    = char_reg;
    ack_next     = 1'b0;
    res_stb_next = res_stb_reg;
    res_val_next = res_val_reg;
    wr_en        = 1'b0;
    wr_addr      = idx_push;
    wr_data      = '0;
`ifdef RPN_EVAL_DIV_EN
    div_cnt_next = div_cnt_reg;
    div_quo_next = div_quo_reg;
    div_den_next = div_den_reg;
    div_rem_next = div_rem_reg;
    div_neg_next = div_neg_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (IN_STB && !ack_reg) begin
          ack_next = 1'b1;
          if (IN_CHAR == 8'h3D) begin
            state_next   = DONE;
            res_stb_next = 1'b1;
            res_val_next = '0;
            if (!err_reg) begin
              if (depth_reg == DW'(1)) begin
                res_val_next = top_b;
              end else begin
                err_next  = 1'b1;
                code_next = CODE_UNBAL;
              end
            end
          end else begin
            char_next  = IN_CHAR;
            state_next = EXEC;
          end
        end
      end
      EXEC: begin
        state_next = IDLE;
        // After the first error every character is only acked and dropped.
        if (!err_reg) begin
          if (is_digit) begin
            if (depth_reg == DW'(DEPTH)) begin
              err_next  = 1'b1;
              code_next = CODE_OVER;
            end else begin
              wr_en      = 1'b1;
              wr_data    = WIDTH'(char_reg[3:0]);
              depth_next = depth_reg + DW'(1);
            end
          end else if (is_arith) begin
            if (depth_reg < DW'(2)) begin
              err_next  = 1'b1;
              code_next = CODE_UNDER;
            end else begin
              wr_en      = 1'b1;
              wr_addr    = idx_a;
              wr_data    = arith_res;
              depth_next = depth_reg - DW'(1);
            end
          end
`ifdef RPN_EVAL_DIV_EN
          else if (char_reg == 8'h2F) begin
            if (depth_reg < DW'(2)) begin
              err_next  = 1'b1;
              code_next = CODE_UNDER;
            end else if (top_b == '0) begin
              err_next  = 1'b1;
              code_next = CODE_DIV0;
            end else begin
              state_next   = DIV;
              div_cnt_next = '0;
              div_quo_next = top_a[WIDTH-1] ? -top_a : top_a;
              div_den_next = top_b[WIDTH-1] ? -top_b : top_b;
              div_rem_next = '0;
              div_neg_next = top_a[WIDTH-1] ^ top_b[WIDTH-1];
            end
          end
`endif
          else begin
            err_next  = 1'b1;
            code_next = CODE_ILLEGAL;
          end
        end
      end
`ifdef RPN_EVAL_DIV_EN
      DIV: begin
        div_cnt_next = div_cnt_reg + CW'(1);
        div_quo_next = quo_shift;
        div_rem_next = rem_step;
        if (div_cnt_reg == CW'(WIDTH - 1)) begin
          wr_en      = 1'b1;
          wr_addr    = idx_a;
          wr_data    = quo_signed;
          depth_next = depth_reg - DW'(1);
          state_next = IDLE;
        end
      end
`endif
      DONE: begin
        if (RES_ACK) begin
          state_next   = IDLE;
          res_stb_next = 1'b0;
          res_val_next = '0;
          depth_next   = '0;
          err_next     = 1'b0;
          code_next    = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg   <= IDLE;
      depth_reg   <= '0;
      err_reg     <= 1'b0;
      code_reg    <= '0;
      char_reg    <= '0;
      ack_reg     <= 1'b0;
      res_stb_reg <= 1'b0;
      res_val_reg <= '0;
    end else begin
      state_reg   <= state_next;
      depth_reg   <= depth_next;
      err_reg     <= err_next;
      code_reg    <= code_next;
      char_reg    <= char_next;
      ack_reg     <= ack_next;
      res_stb_reg <= res_stb_next;
      res_val_reg <= res_val_next;
    end
  end

  // Stack contents need no reset: depth alone decides which entries are live.
  always_ff @(posedge CLK) begin
    if (wr_en) stack_mem[wr_addr] <= wr_data;
  end

  assign IN_ACK   = ack_reg;
  assign RES_STB  = res_stb_reg;
  assign RES_VAL  = res_val_reg;
  assign RES_ERR  = res_stb_reg & err_reg;
  assign RES_CODE = res_stb_reg ? code_reg : 3'd0;
  assign BUSY     = (state_reg != IDLE);

endmodule
